// File: rtl/riscv_core_pipe_ctrl_if.sv
// Control bus between the riscv_core pipeline stages and the pipeline controller.
// The master side drives the per-stage requests; the slave side (the controller) returns the effective controls.
interface riscv_core_pipe_ctrl_if #(
   parameter int STAGES = 5,
   parameter int CNT_W  = 4
);
   logic [STAGES-1:0] stall_d;
   logic [STAGES-1:0] clear_d;
   logic              issue_valid;
   logic              mc_start;
   logic [CNT_W-1:0]  mc_cycles;
   logic [STAGES-1:0] stall_q;
   logic [STAGES-1:0] clear_q;
   logic [STAGES-1:0] valid_q;
   logic              mc_busy;
   logic              retire;

   modport master (
      output stall_d, clear_d, issue_valid, mc_start, mc_cycles,
      input  stall_q, clear_q, valid_q, mc_busy, retire
   );

   modport slave (
      input  stall_d, clear_d, issue_valid, mc_start, mc_cycles,
      output stall_q, clear_q, valid_q, mc_busy, retire
   );
endinterface

// File: rtl/riscv_core_pipe_ctrl.sv
// Parametrised pipeline controller: stall back-propagation, clear fan-out, per-stage occupancy
// tracking with bubble insertion, and a multi-cycle stall counter owned by stage MC_IDX.
module riscv_core_pipe_ctrl #(
   parameter int STAGES = 5,
   parameter int MC_IDX = 2,
   parameter int CNT_W  = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   riscv_core_pipe_ctrl_if.slave  bus
);
   logic [CNT_W-1:0]  r_cnt;
   logic [STAGES-1:0] r_valid;

   logic [STAGES-1:0] w_clear;
   logic [STAGES-1:0] w_req;
   logic [STAGES-1:0] w_stall;
   logic [STAGES-1:0] w_valid_nxt;
   logic              w_cnt_nz;
   logic              w_start_ok;
   logic              w_mc_stall;

   // A clear or stall at stage j reaches every younger stage; clear wins over stall within a stage.
   always_comb begin
      w_cnt_nz   = (r_cnt != '0);
      w_clear    = '0;
      for (int i = 0; i < STAGES; i++) begin
         w_clear[i] = |(bus.clear_d >> i);
      end
      w_start_ok = bus.mc_start & ~w_cnt_nz & (bus.mc_cycles != '0) &
                   r_valid[MC_IDX] & ~w_clear[MC_IDX];
      w_mc_stall = (w_cnt_nz | w_start_ok) & ~w_clear[MC_IDX];
      w_req         = bus.stall_d;
      w_req[MC_IDX] = bus.stall_d[MC_IDX] | w_mc_stall;
      w_stall    = '0;
      for (int i = 0; i < STAGES; i++) begin
         w_stall[i] = (|(w_req >> i)) & ~w_clear[i];
      end
   end

   always_comb begin
      w_valid_nxt = '0;
      if (w_clear[0])      w_valid_nxt[0] = 1'b0;
      else if (w_stall[0]) w_valid_nxt[0] = r_valid[0];
      else                 w_valid_nxt[0] = bus.issue_valid;
      for (int i = 1; i < STAGES; i++) begin
         if (w_clear[i])          w_valid_nxt[i] = 1'b0;
         else if (w_stall[i])     w_valid_nxt[i] = r_valid[i];
         else if (w_stall[i-1])   w_valid_nxt[i] = 1'b0;
         else                     w_valid_nxt[i] = r_valid[i-1];
      end
   end

   // The counter keeps running while older stages stall; a clear of its stage aborts it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid <= '0;
         r_cnt   <= '0;
      end else begin
         r_valid <= w_valid_nxt;
         if (w_clear[MC_IDX])  r_cnt <= '0;
         else if (w_cnt_nz)    r_cnt <= r_cnt - CNT_W'(1);
         else if (w_start_ok)  r_cnt <= bus.mc_cycles - CNT_W'(1);
      end
   end

   always_comb begin
      bus.valid_q = r_valid;
      bus.clear_q = '1;
      bus.stall_q = '0;
      bus.mc_busy = 1'b0;
      bus.retire  = 1'b0;
      if (i_rst_n) begin
         bus.clear_q = w_clear;
         bus.stall_q = w_stall;
         bus.mc_busy = w_mc_stall;
         bus.retire  = r_valid[STAGES-1] & ~w_stall[STAGES-1] & ~w_clear[STAGES-1];
      end
   end
endmodule

// File: tb/tb_riscv_core_pipe_ctrl.sv
// Scoreboard bench for riscv_core_pipe_ctrl: directed scenarios then random traffic, checked
// against a cycle-numbered behavioural model of the pipeline.
module tb_riscv_core_pipe_ctrl;
   localparam int S  = 5;
   localparam int MC = 2;
   localparam int CW = 4;

   typedef struct {
      int           cyc;
      logic [S-1:0] stall;
      logic [S-1:0] clear;
      logic [S-1:0] valid;
      logic         busy;
      logic         retire;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   bit   stimDone = 1'b0;

   bit   mValid[S];
   int   cycleNum = 0;
   int   busyEnd  = 0;

   riscv_core_pipe_ctrl_if #(.STAGES(S), .CNT_W(CW)) bus ();

   riscv_core_pipe_ctrl #(.STAGES(S), .MC_IDX(MC), .CNT_W(CW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string nm, input int cyc, input logic [S-1:0] got,
                              input logic [S-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d got %b want %b", nm, cyc, got, want);
      end
   endtask

   // Drive one cycle of inputs, then predict outputs and advance the model.
   task automatic applyStimulus(input logic rst, input logic [S-1:0] sd, input logic [S-1:0] cd,
                                input logic iv, input logic ms, input logic [CW-1:0] mcy);
      exp_t e;
      bit   clr[S];
      bit   stl[S];
      bit   nxt[S];
      bit   busy;
      bit   startOk;
      logic [S-1:0] req;
      @(posedge clk);
      #1;
      rst_n           = rst;
      bus.stall_d     = sd;
      bus.clear_d     = cd;
      bus.issue_valid = iv;
      bus.mc_start    = ms;
      bus.mc_cycles   = mcy;
      #1;
      e.cyc = cycleNum;
      for (int i = 0; i < S; i++) e.valid[i] = mValid[i];
      if (!rst) begin
         e.clear  = '1;
         e.stall  = '0;
         e.busy   = 1'b0;
         e.retire = 1'b0;
         for (int i = 0; i < S; i++) mValid[i] = 1'b0;
         busyEnd = 0;
      end else begin
         for (int i = 0; i < S; i++) clr[i] = ((cd >> i) != 0);
         startOk = ms && !(cycleNum < busyEnd) && (mcy != 0) && mValid[MC] && !clr[MC];
         if (startOk) busyEnd = cycleNum + int'(mcy);
         busy = !clr[MC] && (cycleNum < busyEnd);
         if (clr[MC]) busyEnd = 0;
         req = sd;
         if (busy) req[MC] = 1'b1;
         for (int i = 0; i < S; i++) begin
            stl[i]     = ((req >> i) != 0) && !clr[i];
            e.stall[i] = stl[i];
            e.clear[i] = clr[i];
         end
         e.busy   = busy;
         e.retire = mValid[S-1] && !stl[S-1] && !clr[S-1];
         for (int i = 0; i < S; i++) begin
            if (clr[i])          nxt[i] = 1'b0;
            else if (stl[i])     nxt[i] = mValid[i];
            else if (i == 0)     nxt[i] = iv;
            else if (stl[i-1])   nxt[i] = 1'b0;
            else                 nxt[i] = mValid[i-1];
         end
         mValid = nxt;
      end
      expQ.push_back(e);
      cycleNum++;
   endtask

   initial begin
      logic [S-1:0] rs;
      logic [S-1:0] rc;
      rst_n           = 1'b0;
      bus.stall_d     = '0;
      bus.clear_d     = '0;
      bus.issue_valid = 1'b0;
      bus.mc_start    = 1'b0;
      bus.mc_cycles   = '0;
      for (int i = 0; i < S; i++) mValid[i] = 1'b0;
      for (int k = 0; k < 2; k++)
         applyStimulus(1'b0, S'($urandom), S'($urandom), 1'($urandom), 1'($urandom), CW'($urandom));
      for (int k = 0; k < 6; k++) applyStimulus(1'b1, '0, '0, 1'b1, 1'b0, '0);
      applyStimulus(1'b1, 5'b00100, '0, 1'b1, 1'b0, '0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, '0, '0, 1'b1, 1'b0, '0);
      applyStimulus(1'b1, 5'b10000, 5'b01000, 1'b1, 1'b0, '0);
      for (int k = 0; k < 6; k++) applyStimulus(1'b1, '0, '0, 1'b1, 1'b0, '0);
      applyStimulus(1'b1, '0, '0, 1'b1, 1'b1, 4'd3);
      applyStimulus(1'b1, '0, '0, 1'b1, 1'b1, 4'd5);
      for (int k = 0; k < 5; k++) applyStimulus(1'b1, '0, '0, 1'b1, 1'b0, '0);
      applyStimulus(1'b1, '0, '0, 1'b1, 1'b1, 4'd0);
      applyStimulus(1'b1, '0, '0, 1'b1, 1'b0, '0);
      applyStimulus(1'b1, '0, '0, 1'b1, 1'b1, 4'd7);
      applyStimulus(1'b1, '0, '0, 1'b1, 1'b0, '0);
      applyStimulus(1'b1, '0, 5'b10000, 1'b1, 1'b0, '0);
      for (int k = 0; k < 8; k++) applyStimulus(1'b1, '0, '0, 1'b1, 1'b0, '0);
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < S; b++) begin
            rs[b] = ($urandom_range(0, 7) == 0);
            rc[b] = ($urandom_range(0, 31) == 0);
         end
         applyStimulus($urandom_range(0, 99) != 0, rs, rc, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 5) == 0,
                       ($urandom_range(0, 1) != 0) ? CW'($urandom_range(0, 4)) : CW'($urandom));
      end
      stimDone = 1'b1;
   end

   // Monitor: the DUT presents a response every cycle; pop and compare away from the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("stall_q", e.cyc, bus.stall_q, e.stall);
            checkOutput("clear_q", e.cyc, bus.clear_q, e.clear);
            checkOutput("valid_q", e.cyc, bus.valid_q, e.valid);
            checkOutput("mc_busy", e.cyc, S'(bus.mc_busy), S'(e.busy));
            checkOutput("retire",  e.cyc, S'(bus.retire),  S'(e.retire));
         end
      end
   end

   initial begin
      int waited;
      wait (stimDone);
      waited = 0;
      while (expQ.size() > 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      repeat (2) @(posedge clk);
      if (expQ.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain pending %0d want 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL timeout cycles %0d", cycleNum);
      $fatal(1, "[TB] timeout");
   end
endmodule
